// File: rtl/product_accumulator.sv
// product_accumulator: sums frames of N_TERMS unsigned 8-bit products behind valid/ready handshakes with sticky wrap flag.
module product_accumulator #(
  parameter int N_TERMS = 4,
  parameter int ACC_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_product,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             overflow
);
  localparam int CW = $clog2(N_TERMS + 1);
  typedef enum logic {ACCUM, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n, cnt_b;
  logic [ACC_W-1:0] acc, acc_n, acc_b;
  logic [ACC_W:0] sum;
  logic ovf, ovf_n, ovf_b, beat, hs, last;
  assign in_ready = (state == ACCUM) ? 1'b1 : out_ready;
  assign out_valid = (state == DONE);
  assign acc_out = acc;
  assign overflow = ovf;
  assign beat = in_valid && in_ready;
  assign hs = out_valid && out_ready;
  // A completed handshake empties the frame first, so a simultaneous beat opens the next one.
  always_comb begin
    acc_b = hs ? '0 : acc;
    ovf_b = hs ? 1'b0 : ovf;
    cnt_b = hs ? '0 : cnt;
    sum = {1'b0, acc_b} + {{(ACC_W-7){1'b0}}, in_product};
    last = (cnt_b == CW'(N_TERMS - 1));
    state_n = beat ? (last ? DONE : ACCUM) : (hs ? ACCUM : state);
    acc_n = beat ? sum[ACC_W-1:0] : acc_b;
    ovf_n = beat ? (ovf_b | sum[ACC_W]) : ovf_b;
    cnt_n = beat ? (last ? '0 : cnt_b + CW'(1)) : cnt_b;
  end
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state <= ACCUM;
      cnt <= '0;
      acc <= '0;
      ovf <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      acc <= acc_n;
      ovf <= ovf_n;
    end
  end
endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: directed checks of three parameterisations sharing one stimulus bus.
module tb_product_accumulator;
  logic clk = 0, rst = 0, clr = 0, in_valid = 0, out_ready = 0;
  logic [7:0] in_product = 0;
  logic d4_ir, d4_ov, d4_ovf, d9_ir, d9_ov, d9_ovf, d1_ir, d1_ov, d1_ovf;
  logic [11:0] d4_acc, d1_acc;
  logic [8:0] d9_acc;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  product_accumulator d4 (.clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(d4_ir),
    .in_product(in_product), .out_valid(d4_ov), .out_ready(out_ready), .acc_out(d4_acc), .overflow(d4_ovf));
  product_accumulator #(.N_TERMS(4), .ACC_W(9)) d9 (.clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid),
    .in_ready(d9_ir), .in_product(in_product), .out_valid(d9_ov), .out_ready(out_ready), .acc_out(d9_acc), .overflow(d9_ovf));
  product_accumulator #(.N_TERMS(1), .ACC_W(12)) d1 (.clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid),
    .in_ready(d1_ir), .in_product(in_product), .out_valid(d1_ov), .out_ready(out_ready), .acc_out(d1_acc), .overflow(d1_ovf));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1; in_valid = 0; clr = 0; out_ready = 1;
    step();
    rst = 0;
  endtask
  task automatic feed(input logic [7:0] p);
    in_valid = 1; in_product = p;
    step();
    in_valid = 0;
  endtask
  task automatic test_reset();
    rst = 1; in_valid = 1; in_product = 8'd55; out_ready = 0;
    step();
    rst = 0; in_valid = 0;
    total++; if (d4_ir !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", d4_ir); end
    total++; if (d4_ov !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", d4_ov); end
    total++; if (d4_acc !== 12'd0) begin bad++; $display("FAIL reset_acc got=%0d want=0", d4_acc); end
    total++; if (d4_ovf !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", d4_ovf); end
  endtask
  task automatic test_frame();
    do_reset();
    feed(10); feed(20); feed(30);
    total++; if (d4_ov !== 1'b0) begin bad++; $display("FAIL frame_early_valid got=%b want=0", d4_ov); end
    feed(40);
    total++; if (d4_ov !== 1'b1) begin bad++; $display("FAIL frame_valid got=%b want=1", d4_ov); end
    total++; if (d4_acc !== 12'd100) begin bad++; $display("FAIL frame_acc got=%0d want=100", d4_acc); end
    total++; if (d4_ovf !== 1'b0) begin bad++; $display("FAIL frame_overflow got=%b want=0", d4_ovf); end
    step();
    total++; if (d4_ov !== 1'b0) begin bad++; $display("FAIL frame_valid_one_cycle got=%b want=0", d4_ov); end
  endtask
  task automatic test_back_to_back();
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      feed(8'(i));
      total++;
      if (d4_ov !== (i == 4 || i == 8)) begin bad++; $display("FAIL b2b_valid beat=%0d got=%b want=%b", i, d4_ov, (i == 4 || i == 8)); end
    end
    total++; if (d4_acc !== 12'd26) begin bad++; $display("FAIL b2b_acc got=%0d want=26", d4_acc); end
  endtask
  task automatic test_backpressure();
    do_reset();
    out_ready = 0;
    feed(225); feed(225); feed(225); feed(225);
    total++; if (d4_ov !== 1'b1) begin bad++; $display("FAIL bp_valid got=%b want=1", d4_ov); end
    in_valid = 1; in_product = 5;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (d4_ir !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc=%0d got=%b want=0", i, d4_ir); end
      step();
      total++; if (d4_acc !== 12'd900 || d4_ov !== 1'b1) begin bad++; $display("FAIL bp_hold cyc=%0d acc=%0d valid=%b want=900/1", i, d4_acc, d4_ov); end
    end
    out_ready = 1;
    #1;
    total++; if (d4_ir !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b want=1", d4_ir); end
    step();
    total++; if (d4_ov !== 1'b0 || d4_acc !== 12'd5) begin bad++; $display("FAIL bp_overlap valid=%b acc=%0d want=0/5", d4_ov, d4_acc); end
    feed(5); feed(5);
    total++; if (d4_ov !== 1'b0) begin bad++; $display("FAIL bp_cnt_early got=%b want=0", d4_ov); end
    feed(5);
    total++; if (d4_ov !== 1'b1 || d4_acc !== 12'd20) begin bad++; $display("FAIL bp_next_frame valid=%b acc=%0d want=1/20", d4_ov, d4_acc); end
  endtask
  task automatic test_overflow();
    do_reset();
    feed(225); feed(225); feed(100); feed(0);
    total++; if (d9_ov !== 1'b1 || d9_acc !== 9'd38) begin bad++; $display("FAIL ovf_acc valid=%b acc=%0d want=1/38", d9_ov, d9_acc); end
    total++; if (d9_ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", d9_ovf); end
    feed(1); feed(1); feed(1); feed(1);
    total++; if (d9_ov !== 1'b1 || d9_acc !== 9'd4) begin bad++; $display("FAIL ovf_next_acc valid=%b acc=%0d want=1/4", d9_ov, d9_acc); end
    total++; if (d9_ovf !== 1'b0) begin bad++; $display("FAIL ovf_next_flag got=%b want=0", d9_ovf); end
  endtask
  task automatic test_bubbles();
    logic [6:0] vpat;
    logic [7:0] prods [4];
    int k;
    vpat = 7'b1001011;
    prods = '{50, 0, 7, 1};
    k = 0;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      in_valid = vpat[6-i];
      in_product = in_valid ? prods[k] : 8'd99;
      if (in_valid) k++;
      step();
      if (i == 5) begin
        total++; if (d4_ov !== 1'b0) begin bad++; $display("FAIL bubble_early got=%b want=0", d4_ov); end
      end
    end
    in_valid = 0;
    total++; if (d4_ov !== 1'b1 || d4_acc !== 12'd58) begin bad++; $display("FAIL bubble_acc valid=%b acc=%0d want=1/58", d4_ov, d4_acc); end
  endtask
  task automatic test_abort();
    do_reset();
    feed(5); feed(6);
    clr = 1; in_valid = 1; in_product = 77;
    step();
    clr = 0; in_valid = 0;
    total++; if (d4_ov !== 1'b0 || d4_acc !== 12'd0) begin bad++; $display("FAIL clr_state valid=%b acc=%0d want=0/0", d4_ov, d4_acc); end
    feed(1); feed(2); feed(3);
    total++; if (d4_ov !== 1'b0) begin bad++; $display("FAIL clr_no_valid got=%b want=0", d4_ov); end
    feed(4);
    total++; if (d4_ov !== 1'b1 || d4_acc !== 12'd10 || d4_ovf !== 1'b0) begin bad++; $display("FAIL clr_next valid=%b acc=%0d ovf=%b want=1/10/0", d4_ov, d4_acc, d4_ovf); end
    out_ready = 0; rst = 1;
    step();
    rst = 0;
    total++; if (d4_ir !== 1'b1 || d4_ov !== 1'b0 || d4_acc !== 12'd0 || d4_ovf !== 1'b0) begin bad++; $display("FAIL rst_done ready=%b valid=%b acc=%0d ovf=%b want=1/0/0/0", d4_ir, d4_ov, d4_acc, d4_ovf); end
    step();
    total++; if (d4_ov !== 1'b0) begin bad++; $display("FAIL rst_done_stays got=%b want=0", d4_ov); end
  endtask
  task automatic test_stream();
    logic [7:0] vals [3];
    vals = '{3, 9, 225};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      feed(vals[i]);
      total++; if (d1_ov !== 1'b1 || d1_acc !== 12'(vals[i])) begin bad++; $display("FAIL stream i=%0d valid=%b acc=%0d want=1/%0d", i, d1_ov, d1_acc, vals[i]); end
    end
    step();
    total++; if (d1_ov !== 1'b0) begin bad++; $display("FAIL stream_end got=%b want=0", d1_ov); end
  endtask
  initial begin
    test_reset();
    test_frame();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_bubbles();
    test_abort();
    test_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
